ex_mem_lsu: RTL and testbench
=============================

Name: ex_mem_lsu

Overview:
- Pipeline stage directly downstream of the execute stage; consumes what the id_ex latch feeds into EX.
- Combines the EX→MEM pipeline latch with a byte-serial load/store unit for the 8-bit memory port.
- Non-memory instructions pass through in one cycle.
- Loads and stores run an FSM that issues one byte per handshake. While the FSM is busy, the block raises a stall request to the pipeline controller.

Parameters:
- ADDR_W, 32, byte address width (wraps modulo 2^32).
- MAX_BYTES, 4, largest access size in bytes (word).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state and outputs freeze.
- stall  in  `StallBus  controller stall vector; stall[4] is this stage, stall[5] is mem_wb.
- ex_aluop  in  `AluOpBus  operation from EX.
- ex_wd  in  `RegAddrBus  destination register.
- ex_wreg  in  1  write enable.
- ex_wdata  in  `RegBus  ALU result.
- ex_mem_addr  in  ADDR_W  effective address for loads/stores.
- ex_store_data  in  `RegBus  rs2 value for stores.
- mem_req  out  1  byte request valid.
- mem_we  out  1  1 = store byte.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  store byte.
- mem_ack  in  1  byte accepted or returned this cycle.
- mem_rdata  in  8  load byte; valid when mem_ack is high.
- wb_wd  out  `RegAddrBus  to mem_wb.
- wb_wreg  out  1  to mem_wb.
- wb_wdata  out  `RegBus  to mem_wb.
- stallreq_o  out  1  to controller; combinational, equals (state != IDLE).

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - wb_wd = `NOPRegAddr, wb_wreg = `WriteDisable, wb_wdata = `ZeroWord.
  - Byte counter and load buffer cleared.
- Reset mid-access: the FSM aborts the same cycle; a partially written store is not undone.
- rdy low: nothing changes, including FSM, counter and mem_req.
- Accept rule (IDLE only): when rdy and stall[4]==`NoStop, capture the EX inputs.
  - Non-memory op: wb_* <= ex_* on that edge. Latency is 1 cycle.
  - LB/LBU/SB use n=1 byte. LH/LHU/SH use n=2. LW/SW use n=4.
  - On a memory op: set base, i=0, state <= ACCESS, and drive wb_wreg <= 0 (bubble).
- Bubble rule (IDLE): stall[4]==Stop and stall[5]==NoStop: wb_wreg <= 0, wb_wd <= `NOPRegAddr, wb_wdata <= 0.
- Hold rule (IDLE): stall[4] and stall[5] both Stop: outputs hold.
- ACCESS state:
  - mem_req = 1, mem_addr = base + i (32-bit wrap), mem_we = store.
  - mem_wdata = store_data[8i+7:8i] (little-endian).
  - On a rising edge with mem_ack = 1: load buffer byte i <= mem_rdata, i <= i+1.
  - mem_ack with i < n-1: stay in ACCESS.
  - mem_ack with i == n-1: state <= IDLE, mem_req <= 0.
    - Load: wb_wreg <= latched wreg, wb_wd <= latched wd, wb_wdata <= assembled value (LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend).
    - Store: wb_wreg <= 0.
  - The FSM update takes priority over the stall/bubble rules in the same cycle.
- Total latency for an n-byte access with ack on every cycle: n cycles in ACCESS after the accept edge. stallreq_o is high for exactly those cycles.
- mem_ack while mem_req is low: ignored.
- Alignment: misaligned addresses are legal; bytes go out sequentially. Address wrap: 0xFFFFFFFF+1 = 0x00000000.
- Flushes (ex_jmp_wrong) do not reach this stage; branch resolution happens in EX before accept.

Decomposition:
- Shared defines header holds:
  - existing `AluOpBus, `RegBus, `RegAddrBus, `StallBus, `NOPRegAddr, `ZeroWord, `NoStop/`Stop, `WriteDisable;
  - new load/store opcodes EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU, EX_SB, EX_SH, EX_SW;
  - FSM state encodings LSU_IDLE, LSU_ACCESS.
- One sub-module: lsu_load_align (combinational). It maps (4-byte buffer, opcode) to the 32-bit extended result and the opcode to n.

Test Plan:
- ADD result 0x00000005 to x3, no stalls -> next edge: wb_wd=3, wb_wreg=1, wb_wdata=5; mem_req stays 0.
- LW at 0x100 with ack every cycle, bytes 0x78,0x56,0x34,0x12 -> addrs 0x100..0x103 on 4 cycles, stallreq_o high 4 cycles, then wb_wdata=0x12345678.
- LB at 0x2 with byte 0x80 -> wb_wdata=0xFFFFFF80. LBU with the same byte -> 0x00000080.
- SH data 0xABCD1234 at 0xFFFFFFFF -> writes 0x34@0xFFFFFFFF then 0x12@0x00000000; wb_wreg=0 throughout.
- LW with ack gaps, and rdy low for 2 cycles mid-access -> mem_addr and i frozen during the gaps; result is identical to the gap-free case.
- Reset asserted during byte 2 of SW -> next edge: mem_req=0, state IDLE, stallreq_o=0, all wb outputs at reset values.

Source files
------------

// File: rtl/ex_mem_lsu_pkg.sv
// ex_mem_lsu_pkg
// Shared constants for the EX->MEM stage: pipeline bus widths, stall and
// write-enable encodings, the load/store opcodes recognised by the byte-serial
// LSU, the LSU state encoding, and small opcode/byte helper functions.
package ex_mem_lsu_pkg;

  // Pipeline bus widths
  localparam int ALU_OP_W   = 8;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int STALL_W    = 6;

  // Stall vector positions
  localparam int STALL_THIS = 4;
  localparam int STALL_WB   = 5;

  // Shared encodings
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = 5'd0;
  localparam logic [REG_W-1:0]      ZERO_WORD     = 32'h0000_0000;
  localparam logic                  NO_STOP       = 1'b0;
  localparam logic                  STOP          = 1'b1;
  localparam logic                  WRITE_DISABLE = 1'b0;
  localparam logic                  WRITE_ENABLE  = 1'b1;

  // Load/store opcodes
  localparam logic [ALU_OP_W-1:0] EX_LB  = 8'h20;
  localparam logic [ALU_OP_W-1:0] EX_LH  = 8'h21;
  localparam logic [ALU_OP_W-1:0] EX_LW  = 8'h22;
  localparam logic [ALU_OP_W-1:0] EX_LBU = 8'h23;
  localparam logic [ALU_OP_W-1:0] EX_LHU = 8'h24;
  localparam logic [ALU_OP_W-1:0] EX_SB  = 8'h28;
  localparam logic [ALU_OP_W-1:0] EX_SH  = 8'h29;
  localparam logic [ALU_OP_W-1:0] EX_SW  = 8'h2A;

  // LSU state encoding
  typedef enum logic [0:0] {
    LSU_IDLE   = 1'b0,
    LSU_ACCESS = 1'b1
  } lsu_state_e;

  function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
    case (op)
      EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
    case (op)
      EX_SB, EX_SH, EX_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Little-endian byte lane k of a word
  function automatic logic [7:0] select_byte(input logic [REG_W-1:0] word,
                                             input logic [1:0] k);
    case (k)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      2'd3:    return word[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_lsu_if.sv
// ex_mem_lsu_if
// Byte-wide memory port between the LSU (master) and the memory (slave).
//   mem_req   master->slave  byte request valid
//   mem_we    master->slave  1 = store byte
//   mem_addr  master->slave  byte address
//   mem_wdata master->slave  store byte
//   mem_ack   slave->master  byte accepted / returned this cycle
//   mem_rdata slave->master  load byte, valid with mem_ack
interface ex_mem_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ex_mem_lsu_load_align.sv
// lsu_load_align
// Combinational helper for the LSU.
//   buffer  in   4 assembled load bytes, byte 0 in bits [7:0]
//   op      in   load/store opcode
//   result  out  load value, sign- or zero-extended per opcode
//   nbytes  out  access size in bytes (1, 2 or 4)
module lsu_load_align
  import ex_mem_lsu_pkg::*;
(
  input  logic [REG_W-1:0]    buffer,
  input  logic [ALU_OP_W-1:0] op,
  output logic [REG_W-1:0]    result,
  output logic [2:0]          nbytes
);

  // Extend the assembled bytes according to the load flavour
  always_comb begin
    result = ZERO_WORD;
    case (op)
      EX_LB:   result = {{24{buffer[7]}}, buffer[7:0]};
      EX_LBU:  result = {24'h000000, buffer[7:0]};
      EX_LH:   result = {{16{buffer[15]}}, buffer[15:0]};
      EX_LHU:  result = {16'h0000, buffer[15:0]};
      EX_LW:   result = buffer;
      default: result = buffer;
    endcase
  end

  // Access size for every load/store flavour
  always_comb begin
    nbytes = 3'd1;
    case (op)
      EX_LB, EX_LBU, EX_SB: nbytes = 3'd1;
      EX_LH, EX_LHU, EX_SH: nbytes = 3'd2;
      EX_LW, EX_SW:         nbytes = 3'd4;
      default:              nbytes = 3'd1;
    endcase
  end

endmodule

// File: rtl/ex_mem_lsu.sv
// ex_mem_lsu
// EX->MEM pipeline latch combined with a byte-serial load/store unit.
// Non-memory ops pass to wb_* on the accept edge; loads/stores walk the
// 8-bit memory port one byte per acknowledged cycle while stallreq_o is high.
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low freezes everything
//   stall           controller stall vector (bit 4 this stage, bit 5 mem_wb)
//   ex_*            operation, destination, result, address and store data
//   mem             byte memory port (master side)
//   wb_wd/wreg/wdata  registered outputs to mem_wb
//   stallreq_o      high while the LSU is not idle
module ex_mem_lsu
  import ex_mem_lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [STALL_W-1:0]    stall,
  input  logic [ALU_OP_W-1:0]   ex_aluop,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [REG_W-1:0]      ex_wdata,
  input  logic [ADDR_W-1:0]     ex_mem_addr,
  input  logic [REG_W-1:0]      ex_store_data,
  ex_mem_lsu_if.master          mem,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [REG_W-1:0]      wb_wdata,
  output logic                  stallreq_o
);

  lsu_state_e               state;
  lsu_state_e               state_next;
  logic [2:0]               idx;
  logic [2:0]               idx_next;
  logic [ALU_OP_W-1:0]      op_q;
  logic [REG_ADDR_W-1:0]    wd_q;
  logic                     wreg_q;
  logic [REG_W-1:0]         sdata_q;
  logic [8*MAX_BYTES-1:0]   load_buf;
  logic [8*MAX_BYTES-1:0]   buf_merged;
  logic                     req_q;
  logic                     we_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [7:0]               wdata_q;
  logic [REG_W-1:0]         load_result;
  logic [2:0]               nbytes;
  logic                     ex_is_mem;
  logic                     accept;
  logic                     byte_go;
  logic                     last_byte;
  logic [STALL_W-1:0]       unused_stall_bits;

  assign unused_stall_bits = stall & 6'b001111;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign stallreq_o = (state != LSU_IDLE);
  assign idx_next   = idx + 3'd1;

  // Load buffer with the byte arriving this cycle dropped into lane idx, so
  // the final byte contributes to the result on its own acknowledge edge
  always_comb begin
    buf_merged = load_buf;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (idx == 3'(k)) begin
        buf_merged[8*k +: 8] = mem.mem_rdata;
      end else begin
        buf_merged[8*k +: 8] = load_buf[8*k +: 8];
      end
    end
  end

  lsu_load_align u_load_align (
    .buffer (buf_merged),
    .op     (op_q),
    .result (load_result),
    .nbytes (nbytes)
  );

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_next = state;
    ex_is_mem  = is_load(ex_aluop) | is_store(ex_aluop);
    accept     = 1'b0;
    byte_go    = 1'b0;
    last_byte  = 1'b0;
    case (state)
      LSU_IDLE: begin
        accept = (stall[STALL_THIS] == NO_STOP);
        if (accept && ex_is_mem) begin
          state_next = LSU_ACCESS;
        end else begin
          state_next = LSU_IDLE;
        end
      end
      LSU_ACCESS: begin
        // An acknowledge only counts while a request is actually out
        byte_go   = req_q & mem.mem_ack;
        last_byte = byte_go & (idx == (nbytes - 3'd1));
        if (last_byte) begin
          state_next = LSU_IDLE;
        end else begin
          state_next = LSU_ACCESS;
        end
      end
      default: begin
        state_next = LSU_IDLE;
      end
    endcase
  end

  // State register, access datapath and registered pipeline outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LSU_IDLE;
      idx      <= 3'd0;
      op_q     <= 8'h00;
      wd_q     <= NOP_REG_ADDR;
      wreg_q   <= WRITE_DISABLE;
      sdata_q  <= ZERO_WORD;
      load_buf <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      wb_wd    <= NOP_REG_ADDR;
      wb_wreg  <= WRITE_DISABLE;
      wb_wdata <= ZERO_WORD;
    end else if (rdy) begin
      state <= state_next;
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            if (ex_is_mem) begin
              op_q     <= ex_aluop;
              wd_q     <= ex_wd;
              wreg_q   <= ex_wreg;
              sdata_q  <= ex_store_data;
              idx      <= 3'd0;
              load_buf <= '0;
              req_q    <= 1'b1;
              we_q     <= is_store(ex_aluop);
              addr_q   <= ex_mem_addr;
              wdata_q  <= ex_store_data[7:0];
              wb_wreg  <= WRITE_DISABLE;
            end else begin
              wb_wd    <= ex_wd;
              wb_wreg  <= ex_wreg;
              wb_wdata <= ex_wdata;
            end
          end else if (stall[STALL_WB] == NO_STOP) begin
            wb_wd    <= NOP_REG_ADDR;
            wb_wreg  <= WRITE_DISABLE;
            wb_wdata <= ZERO_WORD;
          end else begin
            wb_wd    <= wb_wd;
          end
        end
        LSU_ACCESS: begin
          if (byte_go) begin
            load_buf <= buf_merged;
            idx      <= idx_next;
            if (last_byte) begin
              req_q <= 1'b0;
              we_q  <= 1'b0;
              if (is_load(op_q)) begin
                wb_wd    <= wd_q;
                wb_wreg  <= wreg_q;
                wb_wdata <= load_result;
              end else begin
                wb_wreg  <= WRITE_DISABLE;
              end
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              wdata_q <= select_byte(sdata_q, idx_next[1:0]);
            end
          end else begin
            idx <= idx;
          end
        end
        default: begin
          req_q <= 1'b0;
        end
      endcase
    end else begin
      state <= state;
    end
  end

endmodule

// File: tb/tb_ex_mem_lsu.sv
module tb_ex_mem_lsu;
  import ex_mem_lsu_pkg::*;

  localparam logic [7:0] OP_ADD = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall;
  logic [7:0]  ex_aluop;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq_o;

  ex_mem_lsu_if #(.ADDR_W(32)) mif ();

  ex_mem_lsu #(.ADDR_W(32), .MAX_BYTES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .stall         (stall),
    .ex_aluop      (ex_aluop),
    .ex_wd         (ex_wd),
    .ex_wreg       (ex_wreg),
    .ex_wdata      (ex_wdata),
    .ex_mem_addr   (ex_mem_addr),
    .ex_store_data (ex_store_data),
    .mem           (mif),
    .wb_wd         (wb_wd),
    .wb_wreg       (wb_wreg),
    .wb_wdata      (wb_wdata),
    .stallreq_o    (stallreq_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
  } acc_t;

  acc_t       exp_q[$];
  logic [7:0] mem_b [logic [31:0]];
  bit         cmp_en = 1'b0;
  bit         cmp_busy;
  acc_t       cmp_e;
  int         cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return 8'h00;
  endfunction

  function automatic int nbytes_of(input logic [7:0] op);
    if (op == EX_LW || op == EX_SW) return 4;
    if (op == EX_LH || op == EX_LHU || op == EX_SH) return 2;
    return 1;
  endfunction

  // Value a load must return, from the bench memory image
  function automatic logic [31:0] load_value(input logic [7:0] op, input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < nbytes_of(op); k++) v = v | (32'(rd(a + 32'(k))) << (8 * k));
    if (op == EX_LB && v >= 32'd128) v = v + 32'hFFFF_FF00;
    if (op == EX_LH && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  // Every cycle: busy/request/bubble consistency, and each accepted byte
  // against the next expected access
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_busy = (exp_q.size() != 0);
      check("stallreq_o", 32'(stallreq_o), 32'(cmp_busy));
      check("mem_req", 32'(mif.mem_req), 32'(cmp_busy));
      if (cmp_busy) check("wb_wreg_busy", 32'(wb_wreg), 32'd0);
      if (cmp_busy && rdy && mif.mem_ack && !rst) begin
        cmp_e = exp_q.pop_front();
        check("mem_addr", mif.mem_addr, cmp_e.addr);
        check("mem_we", 32'(mif.mem_we), 32'(cmp_e.we));
        if (cmp_e.we) begin
          check("mem_wdata", 32'(mif.mem_wdata), 32'(cmp_e.data));
          mem_b[cmp_e.addr] = cmp_e.data;
        end
      end
    end
  end

  // Issue one load/store; called #1 after a rising edge
  task automatic run_mem(input logic [7:0] op, input logic [4:0] wd,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [15:0] ack_pat, input logic [15:0] rdy_pat,
                         output int cycles);
    logic [31:0] exp_v;
    acc_t e;
    ex_aluop = op; ex_wd = wd; ex_wreg = 1'b1; ex_wdata = 32'h0BAD_0BAD;
    ex_mem_addr = addr; ex_store_data = sdata; stall = 6'b000000; rdy = 1'b1;
    mif.mem_ack = 1'b0;
    exp_v = load_value(op, addr);
    @(posedge clk); #1;
    for (int k = 0; k < nbytes_of(op); k++) begin
      e.addr = addr + 32'(k);
      e.we   = is_store(op);
      e.data = 8'((sdata >> (8 * k)) & 32'hFF);
      exp_q.push_back(e);
    end
    stall = 6'b110000; ex_aluop = OP_ADD; ex_wd = 5'd31; ex_wdata = 32'hFFFF_FFFF;
    cycles = 0;
    while (stallreq_o && cycles < 40) begin
      mif.mem_ack   = ack_pat[cycles % 16];
      rdy           = rdy_pat[cycles % 16];
      mif.mem_rdata = rd(mif.mem_addr);
      @(posedge clk); #1;
      cycles++;
    end
    mif.mem_ack = 1'b0; rdy = 1'b1;
    if (cycles >= 40) begin
      errors++; checks++;
      $display("FAIL access_timeout: op 0x%02h still busy after %0d cycles", op, cycles);
      exp_q.delete();
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    if (is_load(op)) begin
      check("ld_wb_wreg", 32'(wb_wreg), 32'd1);
      check("ld_wb_wd", 32'(wb_wd), 32'(wd));
      check("ld_wb_wdata", wb_wdata, exp_v);
    end else begin
      check("st_wb_wreg", 32'(wb_wreg), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; stall = 6'b000000;
    ex_aluop = 8'h00; ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'h0;
    ex_mem_addr = 32'h0; ex_store_data = 32'h0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 8'h00;
    mem_b[32'h100] = 8'h78; mem_b[32'h101] = 8'h56; mem_b[32'h102] = 8'h34; mem_b[32'h103] = 8'h12;
    mem_b[32'h200] = 8'h78; mem_b[32'h201] = 8'h56; mem_b[32'h202] = 8'h34; mem_b[32'h203] = 8'h12;
    mem_b[32'h2]   = 8'h80;
    mem_b[32'h300] = 8'h00; mem_b[32'h301] = 8'hF0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    check("rst_wb_wd", 32'(wb_wd), 32'd0);
    check("rst_wb_wreg", 32'(wb_wreg), 32'd0);
    check("rst_wb_wdata", wb_wdata, 32'd0);
    check("rst_mem_req", 32'(mif.mem_req), 32'd0);
    check("rst_mem_we", 32'(mif.mem_we), 32'd0);
    check("rst_mem_addr", mif.mem_addr, 32'd0);
    check("rst_mem_wdata", 32'(mif.mem_wdata), 32'd0);
    check("rst_stallreq", 32'(stallreq_o), 32'd0);
    cmp_en = 1'b1;

    // ADD passes through in one cycle; a stray ack is ignored
    ex_aluop = OP_ADD; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h5; mif.mem_ack = 1'b1;
    @(posedge clk); #1; mif.mem_ack = 1'b0;
    check("add_wd", 32'(wb_wd), 32'd3);
    check("add_wreg", 32'(wb_wreg), 32'd1);
    check("add_wdata", wb_wdata, 32'd5);

    // Both stalls: hold
    stall = 6'b110000; ex_wd = 5'd7; ex_wdata = 32'h9;
    @(posedge clk); #1;
    check("hold_wd", 32'(wb_wd), 32'd3);
    check("hold_wdata", wb_wdata, 32'd5);

    // rdy low: freeze even without stall
    stall = 6'b000000; rdy = 1'b0;
    @(posedge clk); #1; rdy = 1'b1;
    check("rdy_wd", 32'(wb_wd), 32'd3);
    check("rdy_wreg", 32'(wb_wreg), 32'd1);

    // This stage stalled, mem_wb not: bubble
    stall = 6'b010000;
    @(posedge clk); #1;
    check("bub_wd", 32'(wb_wd), 32'd0);
    check("bub_wreg", 32'(wb_wreg), 32'd0);
    check("bub_wdata", wb_wdata, 32'd0);

    run_mem(EX_LW, 5'd4, 32'h100, 32'h0, 16'hFFFF, 16'hFFFF, cyc);
    check("lw_cycles", 32'(cyc), 32'd4);
    check("lw_lit", wb_wdata, 32'h1234_5678);

    run_mem(EX_LB, 5'd5, 32'h2, 32'h0, 16'hFFFF, 16'hFFFF, cyc);
    check("lb_cycles", 32'(cyc), 32'd1);
    check("lb_lit", wb_wdata, 32'hFFFF_FF80);

    run_mem(EX_LBU, 5'd6, 32'h2, 32'h0, 16'hFFFF, 16'hFFFF, cyc);
    check("lbu_lit", wb_wdata, 32'h0000_0080);

    run_mem(EX_LH, 5'd7, 32'h300, 32'h0, 16'hFFFF, 16'hFFFF, cyc);
    check("lh_lit", wb_wdata, 32'hFFFF_F000);

    run_mem(EX_LHU, 5'd8, 32'h300, 32'h0, 16'hFFFF, 16'hFFFF, cyc);
    check("lhu_lit", wb_wdata, 32'h0000_F000);

    // Store halfword across the address wrap
    run_mem(EX_SH, 5'd9, 32'hFFFF_FFFF, 32'hABCD_1234, 16'hFFFF, 16'hFFFF, cyc);
    check("sh_cycles", 32'(cyc), 32'd2);
    check("sh_byte_hi_addr", 32'(rd(32'hFFFF_FFFF)), 32'h34);
    check("sh_byte_wrap", 32'(rd(32'h0)), 32'h12);

    run_mem(EX_LH, 5'd10, 32'hFFFF_FFFF, 32'h0, 16'hFFFF, 16'hFFFF, cyc);
    check("lh_wrap_lit", wb_wdata, 32'h0000_1234);

    // Ack gaps plus two rdy-low cycles mid-access
    run_mem(EX_LW, 5'd11, 32'h200, 32'h0, 16'b1111_1111_1101_1010, 16'b1111_1111_1110_0111, cyc);
    check("lw_gap_lit", wb_wdata, 32'h1234_5678);

    // Reset during byte 2 of a store word
    run_mem(EX_LBU, 5'd12, 32'h2, 32'h0, 16'hFFFF, 16'hFFFF, cyc);
    ex_aluop = EX_SW; ex_wd = 5'd13; ex_wreg = 1'b1; ex_mem_addr = 32'h40;
    ex_store_data = 32'hDEAD_BEEF; stall = 6'b000000;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      cmp_e.addr = 32'h40 + 32'(k); cmp_e.we = 1'b1;
      cmp_e.data = 8'((32'hDEAD_BEEF >> (8 * k)) & 32'hFF);
      exp_q.push_back(cmp_e);
    end
    stall = 6'b110000; mif.mem_ack = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    mif.mem_ack = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; exp_q.delete();
    check("rstmid_stallreq", 32'(stallreq_o), 32'd0);
    check("rstmid_mem_req", 32'(mif.mem_req), 32'd0);
    check("rstmid_mem_we", 32'(mif.mem_we), 32'd0);
    check("rstmid_wb_wd", 32'(wb_wd), 32'd0);
    check("rstmid_wb_wreg", 32'(wb_wreg), 32'd0);
    check("rstmid_wb_wdata", wb_wdata, 32'd0);
    check("rstmid_partial", 32'(rd(32'h41)), 32'hBE);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
